// File: rtl/axi_pkg.sv
// Shared AXI3 channel bundles for the crossbar master slots, plus the core-side request bundle.
// Pure types and constants: no latency, no flow control of its own.
package axi_pkg;

  localparam int          AXI_ID_W        = 4;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         addr;
    logic [3:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [1:0]          lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic                valid;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    logic [3:0]          strb;
    logic                last;
    logic                valid;
  } axi_w_t;

  typedef struct packed {
    logic ready;
  } axi_rdy_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [31:0]         data;
    logic [1:0]          resp;
    logic                last;
    logic                valid;
  } axi_r_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
    logic                valid;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t  aw;
    axi_w_t   w;
    axi_rdy_t b;
    axi_ax_t  ar;
    axi_rdy_t r;
  } axi_req_t;

  typedef struct packed {
    axi_rdy_t aw;
    axi_rdy_t w;
    axi_b_t   b;
    axi_rdy_t ar;
    axi_r_t   r;
  } axi_resp_t;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cbus_req_t;

  // Core size code (bytes = 1 << size) to AXI AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_single_master.sv
// Core req/ack port to single-beat AXI3, one transaction outstanding; data_ok 3 cycles after req at best.
// Latency grows one cycle per slave wait; addr_ok stays low while busy and each valid holds until its handshake.
module axi_single_master
  import axi_pkg::*;
#(
  parameter int ID = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output axi_req_t    axi_req,
  input  axi_resp_t   axi_resp
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_DONE} state_t;

  localparam logic [AXI_ID_W-1:0] AXI_ID = AXI_ID_W'(ID);

  state_t      state, state_nxt;
  cbus_req_t   core_req;
  logic        cur_wr;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;
  logic        aw_done, w_done;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ar_vld, aw_vld, w_vld, r_rdy, b_rdy;
  logic        ar_hs, aw_hs, w_hs, r_hs, b_hs;
  axi_ax_t     ax_hdr;
  logic        unused_resp;

  assign core_req = {req, wr, size, addr, wdata, wstrb};

  // Valids/readies decode from registered state only, so reset clears them without a clock.
  assign ar_vld = (state == S_AR);
  assign aw_vld = (state == S_W) && !aw_done;
  assign w_vld  = (state == S_W) && !w_done;
  assign r_rdy  = (state == S_R);
  assign b_rdy  = (state == S_B);

  assign ar_hs = ar_vld && axi_resp.ar.ready;
  assign aw_hs = aw_vld && axi_resp.aw.ready;
  assign w_hs  = w_vld  && axi_resp.w.ready;
  assign r_hs  = r_rdy  && axi_resp.r.valid;
  assign b_hs  = b_rdy  && axi_resp.b.valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_wr    <= 1'b0;
      cur_size  <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_wstrb <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && core_req.req) begin
        cur_wr    <= core_req.wr;
        cur_size  <= core_req.size;
        cur_addr  <= core_req.addr;
        cur_wdata <= core_req.wdata;
        cur_wstrb <= core_req.wstrb;
      end
      if (state == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (r_hs) begin
        rdata_q <= axi_resp.r.data;
        err_q   <= (axi_resp.r.resp != AXI_RESP_OKAY);
      end
      if (b_hs) err_q <= (axi_resp.b.resp != AXI_RESP_OKAY);
    end
  end

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        addr_ok = 1'b1;
        if (core_req.req) state_nxt = core_req.wr ? S_W : S_AR;
      end
      S_AR:   if (ar_hs) state_nxt = S_R;
      S_R:    if (r_hs)  state_nxt = S_DONE;
      // AW and W complete independently, possibly in the same cycle.
      S_W:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_B;
      S_B:    if (b_hs)  state_nxt = S_DONE;
      S_DONE: begin
        data_ok   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ax_hdr       = '0;
    ax_hdr.id    = AXI_ID;
    ax_hdr.addr  = cur_addr;
    ax_hdr.size  = axi_size(cur_size);
    ax_hdr.burst = AXI_BURST_INCR;

    axi_req            = '0;
    axi_req.ar         = ax_hdr;
    axi_req.ar.valid   = ar_vld;
    axi_req.aw         = ax_hdr;
    axi_req.aw.valid   = aw_vld;
    axi_req.w.id       = AXI_ID;
    axi_req.w.data     = cur_wdata;
    axi_req.w.strb     = cur_wstrb;
    axi_req.w.last     = 1'b1;
    axi_req.w.valid    = w_vld;
    axi_req.r.ready    = r_rdy;
    axi_req.b.ready    = b_rdy;
  end

  assign rdata = rdata_q;
  assign err   = err_q;

  // Response IDs are ignored: the crossbar slot is private to this master.
  assign unused_resp = ^{axi_resp.r.id, axi_resp.b.id, axi_resp.r.last, cur_wr};

`ifndef SYNTHESIS
  r_single_beat: assert property (@(posedge clk) disable iff (reset) r_hs |-> axi_resp.r.last);
`endif

endmodule

// File: tb/tb_axi_single_master.sv
// Bench for axi_single_master: directed scenarios plus random mixed traffic against a word-memory model.
module tb_axi_single_master;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        addr_ok, data_ok, err;
  logic [31:0] rdata;
  axi_req_t    axi_req;
  axi_resp_t   axi_resp;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] slv_mem [logic [29:0]];
  logic [31:0] last_rdata;

  axi_ax_t cap_ax;
  axi_w_t  cap_w;
  bit      f_unstable, f_after_hs, f_early_rdy, f_wrong_ch, f_busy_addr_ok, f_start_rdy;
  bit      hold_busy_req;
  int      ax_vld_cycles, rsp_cyc;

  always #5 clk = ~clk;

  axi_single_master #(.ID(5)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err), .axi_req(axi_req), .axi_resp(axi_resp)
  );

  always @(negedge clk) if (!reset && data_ok) pulses++;

  function automatic logic [4:0] hs_bits();
    return {axi_req.ar.valid, axi_req.aw.valid, axi_req.w.valid, axi_req.r.ready, axi_req.b.ready};
  endfunction

  function automatic logic [31:0] init_word(input logic [29:0] idx);
    return {idx[7:0], idx[7:0], idx[7:0], idx[7:0]} ^ 32'hA5C3_5A3C;
  endfunction

  function automatic logic [31:0] mem_rd(input bit slv, input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    if (slv) return slv_mem.exists(idx) ? slv_mem[idx] : init_word(idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  task automatic mem_wr(input bit slv, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] v;
    v = mem_rd(slv, a);
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    if (slv) slv_mem[a[31:2]] = v;
    else     ref_mem[a[31:2]] = v;
  endtask

  // Acts as core (one request) and as AXI slave with the given wait counts; lat = cycle of data_ok, -1 on timeout.
  task automatic run_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input int d_ax,
                         input int d_w, input int d_rsp, input logic [1:0] rsp, output int lat);
    bit ax_hs, w_hs, rsp_hs, ax_go, w_go, rsp_go, ax_seen, w_seen, rdy;
    axi_ax_t ax_p, ax_prev;
    axi_w_t  w_p, w_prev;
    int ax_cnt, w_cnt, rsp_cnt;
    ax_hs = 0; w_hs = 0; rsp_hs = 0; ax_go = 0; w_go = 0; rsp_go = 0; ax_seen = 0; w_seen = 0;
    ax_prev = '0; w_prev = '0; ax_cnt = 0; w_cnt = 0; rsp_cnt = 0;
    lat = -1; rsp_cyc = -1; ax_vld_cycles = 0;
    f_unstable = 0; f_after_hs = 0; f_early_rdy = 0; f_wrong_ch = 0; f_busy_addr_ok = 0;
    @(negedge clk);
    f_start_rdy = addr_ok;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd; wstrb = ws;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (hold_busy_req) begin wr = ~w; addr = a ^ 32'h100; end
      else req = 1'b0;
      if (ax_go) ax_hs = 1;
      if (w_go) w_hs = 1;
      if (rsp_go) rsp_hs = 1;
      ax_go = 0; w_go = 0; rsp_go = 0;
      axi_resp = '0;
      if (data_ok) begin lat = cyc; break; end
      if (addr_ok) f_busy_addr_ok = 1;
      if (w ? axi_req.ar.valid : (axi_req.aw.valid || axi_req.w.valid)) f_wrong_ch = 1;
      ax_p = w ? axi_req.aw : axi_req.ar;
      if (ax_hs) begin
        if (ax_p.valid) f_after_hs = 1;
      end else begin
        if (ax_seen && ax_p != ax_prev) f_unstable = 1;
        if (ax_p.valid) begin
          ax_seen = 1; ax_prev = ax_p; ax_vld_cycles++;
          if (ax_cnt >= d_ax) begin
            ax_go = 1; cap_ax = ax_p;
            if (w) axi_resp.aw.ready = 1'b1;
            else   axi_resp.ar.ready = 1'b1;
          end else ax_cnt++;
        end
      end
      if (w) begin
        w_p = axi_req.w;
        if (w_hs) begin
          if (w_p.valid) f_after_hs = 1;
        end else begin
          if (w_seen && w_p != w_prev) f_unstable = 1;
          if (w_p.valid) begin
            w_seen = 1; w_prev = w_p;
            if (w_cnt >= d_w) begin
              w_go = 1; cap_w = w_p; axi_resp.w.ready = 1'b1;
            end else w_cnt++;
          end
        end
      end
      rdy = w ? axi_req.b.ready : axi_req.r.ready;
      if (rdy && !(ax_hs && (!w || w_hs))) f_early_rdy = 1;
      if (ax_hs && (!w || w_hs) && !rsp_hs) begin
        if (rsp_cnt >= d_rsp) begin
          if (w) begin
            axi_resp.b.valid = 1'b1; axi_resp.b.resp = rsp; axi_resp.b.id = cap_ax.id;
          end else begin
            axi_resp.r.valid = 1'b1; axi_resp.r.resp = rsp; axi_resp.r.last = 1'b1;
            axi_resp.r.id = cap_ax.id; axi_resp.r.data = mem_rd(1'b1, cap_ax.addr);
          end
          if (rdy) begin
            rsp_go = 1; rsp_cyc = cyc;
            if (w) mem_wr(1'b1, cap_ax.addr, cap_w.data, cap_w.strb);
          end
        end else rsp_cnt++;
      end
    end
    req = 1'b0;
    axi_resp = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (hs_bits() !== 5'b0) begin bad++; $display("FAIL reset_hs got=%b exp=00000", hs_bits()); end
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL reset_addr_ok got=%b exp=1", addr_ok); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok got=%b exp=0", data_ok); end
    total++; if ({err, rdata} !== 33'h0) begin bad++; $display("FAIL reset_rdata_err got=%b/%h exp=0/0", err, rdata); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL release_addr_ok got=%b exp=1", addr_ok); end
  endtask

  task automatic test_read_zero_wait();
    int lat;
    mem_wr(1'b1, 32'h1FC0_0004, 32'hDEAD_BEEF, 4'hF);
    mem_wr(1'b0, 32'h1FC0_0004, 32'hDEAD_BEEF, 4'hF);
    run_txn(1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_OKAY, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    total++; if (rdata !== 32'hDEAD_BEEF || err !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b exp=deadbeef/0", rdata, err); end
    total++; if (cap_ax.addr !== 32'h1FC0_0004 || cap_ax.size !== 3'b010) begin bad++; $display("FAIL rd_ar_addr got=%h/%b exp=1fc00004/010", cap_ax.addr, cap_ax.size); end
    total++; if ({cap_ax.len, cap_ax.burst, cap_ax.lock, cap_ax.cache, cap_ax.prot, cap_ax.id} !== {4'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd5}) begin
      bad++; $display("FAIL rd_ar_const got=len%0d burst%b id%0d exp=len0 burst01 id5", cap_ax.len, cap_ax.burst, cap_ax.id); end
    total++; if (f_wrong_ch || f_early_rdy || f_unstable) begin bad++; $display("FAIL rd_protocol got=%b%b%b exp=000", f_wrong_ch, f_early_rdy, f_unstable); end
    last_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin bad++; $display("FAIL rd_pulse_width got=%b/%b exp=0/1", data_ok, addr_ok); end
  endtask

  task automatic test_write_skew();
    int lat;
    mem_wr(1'b0, 32'hBFAF_F000, 32'h1234_5678, 4'b0011);
    run_txn(1'b1, 2'd1, 32'hBFAF_F000, 32'h1234_5678, 4'b0011, 2, 0, 0, AXI_RESP_OKAY, lat);
    total++; if (lat !== 5 || lat !== rsp_cyc + 1) begin bad++; $display("FAIL wr_latency got=%0d (b at %0d) exp=5", lat, rsp_cyc); end
    total++; if (f_after_hs || f_unstable) begin bad++; $display("FAIL wr_valid_hold got=after_hs%b unstable%b exp=0 0", f_after_hs, f_unstable); end
    total++; if (f_early_rdy) begin bad++; $display("FAIL wr_bready_early got=1 exp=0"); end
    total++; if (cap_w.data !== 32'h1234_5678 || cap_w.strb !== 4'b0011 || cap_w.last !== 1'b1) begin
      bad++; $display("FAIL wr_w_payload got=%h/%b/%b exp=12345678/0011/1", cap_w.data, cap_w.strb, cap_w.last); end
    total++; if (cap_ax.addr !== 32'hBFAF_F000 || cap_ax.size !== 3'b001) begin bad++; $display("FAIL wr_aw_addr got=%h/%b exp=bfaff000/001", cap_ax.addr, cap_ax.size); end
    total++; if (rdata !== last_rdata || err !== 1'b0) begin bad++; $display("FAIL wr_rdata_hold got=%h/%b exp=%h/0", rdata, err, last_rdata); end
  endtask

  task automatic test_error();
    int lat;
    logic [31:0] exp;
    exp = mem_rd(1'b0, 32'h0000_1010);
    run_txn(1'b0, 2'd2, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 1, AXI_RESP_SLVERR, lat);
    total++; if (err !== 1'b1 || lat !== 4) begin bad++; $display("FAIL err_slverr got=%b lat%0d exp=1 lat4", err, lat); end
    run_txn(1'b0, 2'd2, 32'h0000_1010, 32'h0, 4'h0, 0, 0, 0, AXI_RESP_OKAY, lat);
    total++; if (err !== 1'b0 || rdata !== exp) begin bad++; $display("FAIL err_okay_after got=%b/%h exp=0/%h", err, rdata, exp); end
    last_rdata = exp;
    run_txn(1'b1, 2'd2, 32'h0000_1014, 32'h0BAD_F00D, 4'hF, 1, 1, 0, 2'b11, lat);
    mem_wr(1'b0, 32'h0000_1014, 32'h0BAD_F00D, 4'hF);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_bresp got=%b exp=1", err); end
  endtask

  task automatic test_backpressure();
    int lat;
    hold_busy_req = 1;
    run_txn(1'b0, 2'd2, 32'h0000_1020, 32'h0, 4'h0, 5, 0, 0, AXI_RESP_OKAY, lat);
    hold_busy_req = 0;
    last_rdata = mem_rd(1'b0, 32'h0000_1020);
    total++; if (ax_vld_cycles !== 6 || f_unstable) begin bad++; $display("FAIL bp_ar_hold got=%0d cycles unstable%b exp=6 0", ax_vld_cycles, f_unstable); end
    total++; if (f_busy_addr_ok || f_wrong_ch) begin bad++; $display("FAIL bp_busy_req got=addr_ok%b wrong_ch%b exp=0 0", f_busy_addr_ok, f_wrong_ch); end
    total++; if (lat !== 8 || rdata !== last_rdata) begin bad++; $display("FAIL bp_result got=lat%0d %h exp=lat8 %h", lat, rdata, last_rdata); end
    repeat (2) @(negedge clk);
    total++; if (hs_bits() !== 5'b0 || addr_ok !== 1'b1) begin bad++; $display("FAIL bp_no_replay got=%b/%b exp=00000/1", hs_bits(), addr_ok); end
  endtask

  task automatic test_reset_mid();
    int p0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h0000_1040; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    @(negedge clk);
    req = 1'b0; axi_resp.aw.ready = 1'b1; axi_resp.w.ready = 1'b1;
    @(negedge clk);
    axi_resp = '0;
    total++; if (hs_bits() !== 5'b00001) begin bad++; $display("FAIL mid_in_b got=%b exp=00001", hs_bits()); end
    p0 = pulses;
    #2 reset = 1'b1;
    #1;
    total++; if (hs_bits() !== 5'b0 || addr_ok !== 1'b1 || data_ok !== 1'b0) begin
      bad++; $display("FAIL mid_async got=%b/%b/%b exp=00000/1/0", hs_bits(), addr_ok, data_ok); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (addr_ok !== 1'b1 || pulses !== p0 || {err, rdata} !== 33'h0) begin
      bad++; $display("FAIL mid_release got=addr_ok%b pulses+%0d %b/%h exp=1 +0 0/0", addr_ok, pulses - p0, err, rdata); end
    last_rdata = 32'h0;
  endtask

  task automatic test_back_to_back();
    int p0, lat, exp_lat, d_ax, d_w, d_r;
    bit w;
    logic [1:0] sz, rsp;
    logic [31:0] a, wd, exp_rd;
    logic [3:0] ws;
    logic [2:0] off;
    p0 = pulses;
    for (int i = 0; i < 100; i++) begin
      w = i[0];
      sz = 2'($urandom_range(0, 2));
      off = 3'($urandom_range(0, 3)) & ~((3'd1 << sz) - 3'd1);
      a = 32'h0000_1000 + 32'($urandom_range(0, 15)) * 4 + 32'(off);
      wd = $urandom;
      ws = 4'((5'd1 << (3'd1 << sz)) - 5'd1) << off;
      d_ax = $urandom_range(0, 3); d_w = $urandom_range(0, 3); d_r = $urandom_range(0, 3);
      rsp = ($urandom_range(0, 3) == 3) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      if ($urandom_range(0, 1) == 1) begin
        axi_resp.ar.ready = 1'b1; axi_resp.aw.ready = 1'b1; axi_resp.w.ready = 1'b1;
      end
      exp_lat = w ? 3 + ((d_ax > d_w) ? d_ax : d_w) + d_r : 3 + d_ax + d_r;
      run_txn(w, sz, a, wd, ws, d_ax, d_w, d_r, rsp, lat);
      if (w) mem_wr(1'b0, a, wd, ws);
      else   last_rdata = mem_rd(1'b0, a);
      exp_rd = last_rdata;
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL b2b_lat[%0d] got=%0d exp=%0d", i, lat, exp_lat); end
      total++; if (rdata !== exp_rd || err !== (rsp != AXI_RESP_OKAY)) begin
        bad++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/%b", i, rdata, err, exp_rd, rsp != AXI_RESP_OKAY); end
      total++; if (cap_ax.addr !== a || cap_ax.size !== {1'b0, sz} || (w && (cap_w.data !== wd || cap_w.strb !== ws))) begin
        bad++; $display("FAIL b2b_payload[%0d] got=%h/%b exp=%h/%b", i, cap_ax.addr, cap_ax.size, a, {1'b0, sz}); end
      total++; if ({f_unstable, f_after_hs, f_early_rdy, f_wrong_ch, f_busy_addr_ok, f_start_rdy} !== 6'b000001) begin
        bad++; $display("FAIL b2b_protocol[%0d] got=%b exp=000001", i, {f_unstable, f_after_hs, f_early_rdy, f_wrong_ch, f_busy_addr_ok, f_start_rdy}); end
    end
    @(negedge clk);
    total++; if (pulses - p0 !== 100) begin bad++; $display("FAIL b2b_pulses got=%0d exp=100", pulses - p0); end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wdata = '0; wstrb = '0;
    axi_resp = '0; hold_busy_req = 0; last_rdata = '0; cap_ax = '0; cap_w = '0;
    test_reset();
    test_read_zero_wait();
    test_write_skew();
    test_error();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
